// File: rtl/multi_sector_cache_if.sv
// Bus bundle for the multi-sector cache.
// Groups the host port (a_*), the disk/serialiser port (b_*), the per-sector
// dirty flags and the flush handshake. clk and rst_n stay plain module ports.
//   master : drives addresses, write data/strobes, flush_req, flush_ack
//   slave  : the cache; drives read data, dirty, flush_busy/valid/sector/done
interface multi_sector_cache_if #(
  parameter int DATA_W       = 8,
  parameter int SECTOR_BYTES = 512,
  parameter int NUM_SECTORS  = 4
);
  localparam int OFF_W  = $clog2(SECTOR_BYTES);
  localparam int SEC_W  = $clog2(NUM_SECTORS);
  localparam int ADDR_W = SEC_W + OFF_W;

  logic [ADDR_W-1:0]      a_addr;
  logic [DATA_W-1:0]      a_din;
  logic                   a_wr_en;
  logic [DATA_W-1:0]      a_dout;
  logic [ADDR_W-1:0]      b_addr;
  logic [DATA_W-1:0]      b_din;
  logic                   b_wr_en;
  logic [DATA_W-1:0]      b_dout;
  logic [NUM_SECTORS-1:0] dirty;
  logic                   flush_req;
  logic                   flush_busy;
  logic                   flush_valid;
  logic [SEC_W-1:0]       flush_sector;
  logic                   flush_ack;
  logic                   flush_done;

  modport master (
    output a_addr, a_din, a_wr_en, b_addr, b_din, b_wr_en, flush_req, flush_ack,
    input  a_dout, b_dout, dirty, flush_busy, flush_valid, flush_sector, flush_done
  );

  modport slave (
    input  a_addr, a_din, a_wr_en, b_addr, b_din, b_wr_en, flush_req, flush_ack,
    output a_dout, b_dout, dirty, flush_busy, flush_valid, flush_sector, flush_done
  );
endinterface

// File: rtl/multi_sector_cache.sv
// Multi-sector dual-port sector cache with dirty tracking and a flush engine.
// Holds NUM_SECTORS sectors of SECTOR_BYTES words. Port A is the host side
// (write-first, writes mark the sector dirty); port B is the disk side (a
// write leaves b_dout unchanged, never touches dirty). The flush engine walks
// the sectors in ascending order and offers each dirty one on
// flush_valid/flush_sector until flush_ack.
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset (array contents are kept)
//   cache_bus  slave side of multi_sector_cache_if (host/disk ports, dirty,
//              flush_req/busy/valid/sector/ack/done)
module multi_sector_cache #(
  parameter int DATA_W       = 8,
  parameter int SECTOR_BYTES = 512,
  parameter int NUM_SECTORS  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multi_sector_cache_if.slave   cache_bus
);
  localparam int OFF_W  = $clog2(SECTOR_BYTES);
  localparam int SEC_W  = $clog2(NUM_SECTORS);
  localparam int ADDR_W = SEC_W + OFF_W;
  localparam int DEPTH  = NUM_SECTORS * SECTOR_BYTES;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_OFFER = 2'd2,
    ST_DONE  = 2'd3
  } flush_state_t;

  logic [DATA_W-1:0]      mem_r [DEPTH];
  logic [DATA_W-1:0]      a_dout_r;
  logic [DATA_W-1:0]      b_dout_r;
  logic [NUM_SECTORS-1:0] dirty_r;
  flush_state_t           state_r;
  logic [SEC_W-1:0]       idx_r;
  logic                   redirty_r;
  logic                   flush_valid_r;
  logic [SEC_W-1:0]       flush_sector_r;
  logic                   flush_busy_r;
  logic                   flush_done_r;

  logic [SEC_W-1:0]       a_sec_s;
  logic                   a_hit_idx_s;
  logic                   last_idx_s;

  assign a_sec_s     = cache_bus.a_addr[ADDR_W-1:OFF_W];
  // A host write landing in the sector the engine is currently pointing at.
  assign a_hit_idx_s = cache_bus.a_wr_en && (a_sec_s == idx_r);
  assign last_idx_s  = (idx_r == SEC_W'(NUM_SECTORS - 1));

  // Array write ports; port A is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (cache_bus.b_wr_en) begin
      mem_r[cache_bus.b_addr] <= cache_bus.b_din;
    end
    if (cache_bus.a_wr_en) begin
      mem_r[cache_bus.a_addr] <= cache_bus.a_din;
    end
  end

  // Registered read ports; reads see pre-edge array contents (old data on cross-port collisions).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_dout_r <= '0;
      b_dout_r <= '0;
    end else begin
      if (cache_bus.a_wr_en) begin
        a_dout_r <= cache_bus.a_din;
      end else begin
        a_dout_r <= mem_r[cache_bus.a_addr];
      end
      if (!cache_bus.b_wr_en) begin
        b_dout_r <= mem_r[cache_bus.b_addr];
      end
    end
  end

  // Flush engine and dirty flags; host writes set dirty after any flush clear so they always win.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      idx_r          <= '0;
      redirty_r      <= 1'b0;
      flush_valid_r  <= 1'b0;
      flush_sector_r <= '0;
      flush_busy_r   <= 1'b0;
      flush_done_r   <= 1'b0;
      dirty_r        <= '0;
    end else begin
      flush_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cache_bus.flush_req) begin
            state_r      <= ST_SCAN;
            idx_r        <= '0;
            flush_busy_r <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (dirty_r[idx_r]) begin
            state_r        <= ST_OFFER;
            flush_valid_r  <= 1'b1;
            flush_sector_r <= idx_r;
            // The entry edge already counts towards re-dirtying this offer.
            redirty_r      <= a_hit_idx_s;
          end else if (last_idx_s) begin
            state_r <= ST_DONE;
          end else begin
            idx_r <= idx_r + SEC_W'(1);
          end
        end
        ST_OFFER: begin
          if (cache_bus.flush_ack) begin
            flush_valid_r <= 1'b0;
            if (!(redirty_r || a_hit_idx_s)) begin
              dirty_r[idx_r] <= 1'b0;
            end
            if (last_idx_s) begin
              state_r <= ST_DONE;
            end else begin
              idx_r   <= idx_r + SEC_W'(1);
              state_r <= ST_SCAN;
            end
          end else begin
            redirty_r <= redirty_r | a_hit_idx_s;
          end
        end
        ST_DONE: begin
          flush_done_r <= 1'b1;
          flush_busy_r <= 1'b0;
          state_r      <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
      if (cache_bus.a_wr_en) begin
        dirty_r[a_sec_s] <= 1'b1;
      end
    end
  end

  assign cache_bus.a_dout       = a_dout_r;
  assign cache_bus.b_dout       = b_dout_r;
  assign cache_bus.dirty        = dirty_r;
  assign cache_bus.flush_busy   = flush_busy_r;
  assign cache_bus.flush_valid  = flush_valid_r;
  assign cache_bus.flush_sector = flush_sector_r;
  assign cache_bus.flush_done   = flush_done_r;
endmodule
